// File: rtl/data_mem_responder.sv
// Multi-cycle little-endian data memory behind a valid/ready handshake.
// Returns extended load data after LATENCY wait cycles and stalls the pipeline while busy.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqValid,
  input  logic                  ReqWrite,
  input  logic [DATA_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  input  logic [2:0]            ReqFunct3,
  output logic                  ReqReady,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] RespRData,
  output logic                  AccessErr,
  output logic                  StallM
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    aerr_q, aerr_d;

  logic                    accept, illegal, enter_resp, mem_we;
  logic [NBYTES-1:0]       be;
  logic [DATA_WIDTH-1:0]   word_rd, load_ext;
  logic [7:0]              mem [0:(2**ADDR_WIDTH)-1];

  assign accept = (state_q == IDLE) && ReqValid;

  // The *_d fields are the request being worked on: live inputs on the
  // accept edge, the captured copy afterwards.
  always_comb begin
    write_d = accept ? ReqWrite                   : write_q;
    addr_d  = accept ? ReqAddr[ADDR_WIDTH-1:0]   : addr_q;
    wdata_d = accept ? ReqWData                   : wdata_q;
    f3_d    = accept ? ReqFunct3                  : f3_q;
  end

  always_comb begin
    illegal = (f3_d == 3'b011) || (f3_d == 3'b110) || (f3_d == 3'b111) ||
              (write_d && f3_d[2]) ||
              ((f3_d[1:0] == 2'b01) && addr_d[0]) ||
              ((f3_d[1:0] == 2'b10) && (addr_d[1:0] != 2'b00));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ReqValid) begin
        if (illegal || LATENCY == 0) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ReqReady  = (state_q == IDLE);
    RespValid = (state_q == RESP);
    StallM    = ((state_q == IDLE) && ReqValid) || (state_q == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign mem_we     = enter_resp && write_d && !illegal;

  always_comb begin
    word_rd = '0;
    be      = '0;
    for (int k = 0; k < NBYTES; k++) begin
      word_rd[8*k +: 8] = mem[addr_d + ADDR_WIDTH'(k)];
      case (f3_d[1:0])
        2'b00:   be[k] = (k < 1);
        2'b01:   be[k] = (k < 2);
        default: be[k] = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (f3_d)
      3'b000:  load_ext = {{(DATA_WIDTH-8){word_rd[7]}}, word_rd[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){word_rd[15]}}, word_rd[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, word_rd[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, word_rd[15:0]};
      3'b010:  load_ext = word_rd;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    aerr_d  = aerr_q;
    if (enter_resp) begin
      rdata_d = (illegal || write_d) ? '0 : load_ext;
      aerr_d  = illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      rdata_q <= '0;
      aerr_q  <= 1'b0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage is never cleared; reset only blocks a write that would land on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      for (int k = 0; k < NBYTES; k++)
        if (be[k]) mem[addr_d + ADDR_WIDTH'(k)] <= wdata_d[8*k +: 8];
  end

  assign RespRData = rdata_q;
  assign AccessErr = aerr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 0, 3) checked every
// cycle against a timeline model, plus directed requests with literal expectations.
module tb_data_mem_responder;
  localparam int NL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [NL];
  logic        req_write [NL];
  logic [31:0] req_addr  [NL];
  logic [31:0] req_wdata [NL];
  logic [2:0]  req_f3    [NL];
  logic        ready [NL], rv [NL], err [NL], stall [NL];
  logic [31:0] rdata [NL];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_dut
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17),
                         .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 3))) u_dut (
      .clk(clk), .rst(rst),
      .ReqValid(req_valid[g]), .ReqWrite(req_write[g]), .ReqAddr(req_addr[g]),
      .ReqWData(req_wdata[g]), .ReqFunct3(req_f3[g]),
      .ReqReady(ready[g]), .RespValid(rv[g]), .RespRData(rdata[g]),
      .AccessErr(err[g]), .StallM(stall[g]));
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model: request/response timeline per lane ----------------
  int          cyc = 0;
  int          resp_cyc [NL];
  logic [31:0] pend_rd [NL], last_rd [NL];
  logic        pend_err [NL], last_err [NL];
  logic        wr_pend [NL];
  logic [31:0] wr_a [NL], wr_d [NL];
  int          wr_n [NL];
  logic [7:0]  mmem [int];

  function automatic int nbytes(logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic int key(int ln, logic [31:0] a);
    return ln * (1 << 20) + int'(a & 32'h1FFFF);
  endfunction

  function automatic logic is_illegal(logic w, logic [2:0] f3, logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (w && f3 >= 4) return 1'b1;
    return (int'(a[3:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_m(int ln, logic [2:0] f3, logic [31:0] a);
    longint v = 0;
    int n = nbytes(f3);
    for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(mmem[key(ln, a + k)]);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return 32'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      for (int ln = 0; ln < NL; ln++) begin
        resp_cyc[ln] = -1; pend_rd[ln] = 0; last_rd[ln] = 0;
        pend_err[ln] = 0; last_err[ln] = 0; wr_pend[ln] = 0;
      end
    end else begin
      for (int ln = 0; ln < NL; ln++) begin
        if (resp_cyc[ln] < cyc && req_valid[ln]) begin
          logic e;
          e = is_illegal(req_write[ln], req_f3[ln], req_addr[ln]);
          last_rd[ln]  = pend_rd[ln];
          last_err[ln] = pend_err[ln];
          pend_err[ln] = e;
          pend_rd[ln]  = (e || req_write[ln]) ? 32'h0 : load_m(ln, req_f3[ln], req_addr[ln]);
          resp_cyc[ln] = cyc + (e ? 1 : lat_of(ln) + 1);
          if (!e && req_write[ln]) begin
            wr_pend[ln] = 1; wr_a[ln] = req_addr[ln];
            wr_d[ln] = req_wdata[ln]; wr_n[ln] = nbytes(req_f3[ln]);
          end
        end
      end
      cyc++;
      for (int ln = 0; ln < NL; ln++)
        if (wr_pend[ln] && cyc == resp_cyc[ln]) begin
          for (int k = 0; k < wr_n[ln]; k++) mmem[key(ln, wr_a[ln] + k)] = 8'(wr_d[ln] >> (8*k));
          wr_pend[ln] = 0;
        end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int ln = 0; ln < NL; ln++) begin
      if (rst) begin
        chk($sformatf("L%0d rst RespValid", ln), 32'(rv[ln]), 32'd0);
        chk($sformatf("L%0d rst RespRData", ln), rdata[ln], 32'd0);
        chk($sformatf("L%0d rst AccessErr", ln), 32'(err[ln]), 32'd0);
      end else begin
        logic busy, now;
        busy = cyc < resp_cyc[ln];
        now  = cyc == resp_cyc[ln];
        chk($sformatf("L%0d c%0d ReqReady", ln, cyc), 32'(ready[ln]), 32'(!busy && !now));
        chk($sformatf("L%0d c%0d RespValid", ln, cyc), 32'(rv[ln]), 32'(now));
        chk($sformatf("L%0d c%0d StallM", ln, cyc), 32'(stall[ln]),
            32'(busy ? 1'b1 : (now ? 1'b0 : req_valid[ln])));
        chk($sformatf("L%0d c%0d RespRData", ln, cyc), rdata[ln],
            (cyc >= resp_cyc[ln]) ? pend_rd[ln] : last_rd[ln]);
        chk($sformatf("L%0d c%0d AccessErr", ln, cyc), 32'(err[ln]),
            32'((cyc >= resp_cyc[ln]) ? pend_err[ln] : last_err[ln]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic req(int ln, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                     logic [31:0] exp_rd, logic exp_err, string nm);
    int lat, st, exp_lat;
    logic got;
    req_valid[ln] = 1; req_write[ln] = w; req_f3[ln] = f3;
    req_addr[ln] = a; req_wdata[ln] = d;
    st = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready[ln]) begin got = 1; break; end
    end
    chk({nm, " accepted"}, 32'(got), 32'd1);
    if (stall[ln]) st++;
    @(posedge clk); #1;
    req_valid[ln] = 0; req_write[ln] = ~w; req_addr[ln] = ~a; req_wdata[ln] = ~d;
    lat = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rv[ln]) begin got = 1; break; end
      if (stall[ln]) st++;
    end
    exp_lat = exp_err ? 1 : lat_of(ln) + 1;
    chk({nm, " resp latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " stall cycles"}, 32'(st), 32'(exp_lat));
    chk({nm, " RespRData"}, rdata[ln], exp_rd);
    chk({nm, " AccessErr"}, 32'(err[ln]), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic b2b(int ln);
    int nacc = 0, pulses = 0, dbl = 0;
    int acc_c [2];
    logic [31:0] rd_s [2];
    logic prev = 0, acc_now;
    acc_c[0] = 0; acc_c[1] = 0; rd_s[0] = 0; rd_s[1] = 0;
    req_valid[ln] = 1; req_write[ln] = 0; req_f3[ln] = 3'b010; req_addr[ln] = 32'h100;
    for (int cy = 0; cy < 20; cy++) begin
      @(negedge clk);
      if (rv[ln]) begin
        if (pulses < 2) rd_s[pulses] = rdata[ln];
        pulses++;
        if (prev) dbl++;
      end
      prev = rv[ln];
      acc_now = ready[ln] && req_valid[ln];
      if (acc_now) begin
        if (nacc < 2) acc_c[nacc] = cy;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc_now && nacc == 1) req_addr[ln] = 32'h0002_0100;
      if (acc_now && nacc == 2) req_valid[ln] = 0;
    end
    chk($sformatf("L%0d b2b accepts", ln), 32'(nacc), 32'd2);
    chk($sformatf("L%0d b2b accept gap", ln), 32'(acc_c[1] - acc_c[0]), 32'(lat_of(ln) + 2));
    chk($sformatf("L%0d b2b pulses", ln), 32'(pulses), 32'd2);
    chk($sformatf("L%0d b2b wide pulse", ln), 32'(dbl), 32'd0);
    chk($sformatf("L%0d b2b data0", ln), rd_s[0], 32'hCAFE_F00D);
    chk($sformatf("L%0d b2b data1 wrap", ln), rd_s[1], 32'hCAFE_F00D);
  endtask

  initial begin
    for (int ln = 0; ln < NL; ln++) begin
      req_valid[ln] = 0; req_write[ln] = 0; req_addr[ln] = 0;
      req_wdata[ln] = 0; req_f3[ln] = 0;
    end
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset ReqReady", 32'(ready[0]), 32'd1);
    chk("reset RespValid", 32'(rv[0]), 32'd0);
    chk("reset RespRData", rdata[0], 32'd0);
    chk("reset AccessErr", 32'(err[0]), 32'd0);
    chk("reset StallM", 32'(stall[0]), 32'd0);
    @(posedge clk); #1;

    req(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, "sw 100");
    req(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw 100");
    req(0, 0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FFDE, 0, "lb 103");
    req(0, 0, 3'b100, 32'h103, 32'h0, 32'h0000_00DE, 0, "lbu 103");
    req(0, 0, 3'b001, 32'h102, 32'h0, 32'hFFFF_DEAD, 0, "lh 102");
    req(0, 0, 3'b101, 32'h102, 32'h0, 32'h0000_DEAD, 0, "lhu 102");
    req(0, 0, 3'b000, 32'h100, 32'h0, 32'hFFFF_FFEF, 0, "lb 100");
    req(0, 1, 3'b000, 32'h101, 32'h1234_5655, 32'h0, 0, "sb 101");
    req(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_55EF, 0, "lw after sb");
    req(0, 1, 3'b001, 32'h102, 32'hAAAA_7777, 32'h0, 0, "sh 102");
    req(0, 0, 3'b010, 32'h100, 32'h0, 32'h7777_55EF, 0, "lw after sh");
    req(0, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, "lw misaligned");
    req(0, 1, 3'b001, 32'h101, 32'h5555_5555, 32'h0, 1, "sh misaligned");
    req(0, 1, 3'b100, 32'h100, 32'h1111_1111, 32'h0, 1, "store f3=100");
    req(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, "load f3=011");
    req(0, 0, 3'b010, 32'h100, 32'h0, 32'h7777_55EF, 0, "lw after illegal");

    // Reset while a store waits: it must never reach memory.
    req(0, 1, 3'b010, 32'h200, 32'h0, 32'h0, 0, "sw 0 @200");
    req(0, 0, 3'b010, 32'h100, 32'h0, 32'h7777_55EF, 0, "lw before reset");
    req_valid[0] = 1; req_write[0] = 1; req_f3[0] = 3'b010;
    req_addr[0] = 32'h200; req_wdata[0] = 32'h1234_5678;
    @(negedge clk);
    chk("rst-test accept ready", 32'(ready[0]), 32'd1);
    @(posedge clk); #1 req_valid[0] = 0;
    @(posedge clk); #1 rst = 1;
    #1;
    chk("async rst RespValid", 32'(rv[0]), 32'd0);
    chk("async rst RespRData", rdata[0], 32'd0);
    chk("async rst AccessErr", 32'(err[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("after rst ReqReady", 32'(ready[0]), 32'd1);
    req(0, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0, "lw 200 after rst");

    for (int ln = 1; ln < NL; ln++) begin
      req(ln, 1, 3'b010, 32'h100, 32'hCAFE_F00D, 32'h0, 0, $sformatf("L%0d sw 100", ln));
      b2b(ln);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
